// File: rtl/div_if.sv
// Handshake and operand/result bundle between the EX-stage ALU and the divider.
// The ALU drives the request side (master); the divider answers (slave).
interface div_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     opr1;
    logic [WIDTH-1:0]     opr2;
    logic                 cancel;
    logic                 ready;
    logic                 busy;
    logic [2*WIDTH-1:0]   res;

    modport master (
        output start, signed_div, opr1, opr2, cancel,
        input  ready, busy, res
    );

    modport slave (
        input  start, signed_div, opr1, opr2, cancel,
        output ready, busy, res
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on magnitudes,
// signs reapplied at the end. res = {remainder, quotient} feeds the HI/LO write path.
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  resetn,
    div_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, DIVZ, BUSY, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     sgn_q, s1_q, s2_q, divz_q;
    logic [WIDTH-1:0]         prem_q, quo_q, dsor_q;
    logic [2*WIDTH-1:0]       res_q;

    logic                     accept;
    logic                     last_iter;
    logic [WIDTH:0]           prem_sh;
    logic signed [WIDTH:0]    trial;
    logic [WIDTH-1:0]         quo_fix, rem_fix;
    logic [2*WIDTH-1:0]       result;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement magnitude; the most negative value maps onto itself, which
    // is exactly the right unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    assign accept    = (state_q == IDLE) && bus.start && !bus.cancel;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // The trial subtract needs WIDTH+1 bits: the shifted remainder can exceed WIDTH bits.
    assign prem_sh = {prem_q, quo_q[WIDTH-1]};
    assign trial   = $signed(prem_sh - {1'b0, dsor_q});

    // Zero-divisor results are stored raw and must bypass the sign fix-up.
    assign quo_fix = (sgn_q && (s1_q ^ s2_q) && !divz_q) ? negate(quo_q) : quo_q;
    assign rem_fix = (sgn_q && s1_q && !divz_q) ? negate(prem_q) : prem_q;
    assign result  = {rem_fix, quo_fix};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus.ready = 1'b0;
        bus.busy  = (state_q != IDLE);
        bus.res   = res_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (bus.opr2 == '0) ? DIVZ : BUSY;
                end
            end
            DIVZ: state_d = DONE;
            BUSY: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!bus.cancel) begin
                    bus.ready = 1'b1;
                    bus.res   = result;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.cancel && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            sgn_q  <= 1'b0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            divz_q <= 1'b0;
            prem_q <= '0;
            quo_q  <= '0;
            dsor_q <= '0;
            res_q  <= '0;
        end else begin
            if (accept) begin
                sgn_q  <= bus.signed_div;
                s1_q   <= bus.opr1[WIDTH-1];
                s2_q   <= bus.opr2[WIDTH-1];
                cnt_q  <= '0;
                dsor_q <= magnitude(bus.opr2, bus.signed_div);
                if (bus.opr2 == '0) begin
                    divz_q <= 1'b1;
                    prem_q <= bus.opr1;
                    quo_q  <= '1;
                end else begin
                    divz_q <= 1'b0;
                    prem_q <= '0;
                    quo_q  <= magnitude(bus.opr1, bus.signed_div);
                end
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (!trial[WIDTH]) begin
                    prem_q <= trial[WIDTH-1:0];
                    quo_q  <= {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_q <= prem_sh[WIDTH-1:0];
                    quo_q  <= {quo_q[WIDTH-2:0], 1'b0};
                end
            end
            if ((state_q == DONE) && !bus.cancel) begin
                res_q <= result;
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, cancel/reset/back-to-back
// handshakes and randomized operands against a plain-arithmetic reference.
module tb_div_unit;
    logic clk;
    logic resetn;
    int   errors;
    int   checks;
    logic [63:0] last_res;

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called at a negedge with the divider idle; returns at a negedge, idle again.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input logic [63:0] exp, input string tag);
        int lat;
        bus.start      = 1'b1;
        bus.signed_div = sg;
        bus.opr1       = a;
        bus.opr2       = b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.ready && lat < 100);
        chk({tag, " latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        chk({tag, " res"}, bus.res, exp);
        bus.start = 1'b0;
        @(negedge clk);
        chk({tag, " ready drop"}, 64'(bus.ready), 64'd0);
        chk({tag, " res held"}, bus.res, exp);
        last_res = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a, b;
        logic        sg;
        errors = 0;
        checks = 0;
        last_res = 64'd0;
        resetn = 1'b0;
        bus.start = 1'b0;
        bus.signed_div = 1'b0;
        bus.opr1 = '0;
        bus.opr2 = '0;
        bus.cancel = 1'b0;
        #12;
        chk("reset ready", 64'(bus.ready), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset res", bus.res, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, "u100/7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s-7/2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, "s7/-2");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, {32'h1, 32'h7FFF_FFFC}, "uFFFFFFF9/2");
        run_op(32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, "u div0");
        run_op(32'h1234_5678, 32'd0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, "s div0");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, "s ovf");

        // Cancel during BUSY, then a fresh operation two cycles later.
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opr1 = 32'd100; bus.opr2 = 32'd7;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.ready) n++;
        end
        bus.cancel = 1'b1;
        bus.start  = 1'b0;
        @(negedge clk);
        if (bus.ready) n++;
        bus.cancel = 1'b0;
        chk("cancel no ready", 64'(n), 64'd0);
        chk("cancel busy", 64'(bus.busy), 64'd0);
        chk("cancel res", bus.res, last_res);
        @(negedge clk);
        run_op(32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, "after cancel 9/3");

        // Cancel coinciding with DONE suppresses ready and leaves res alone.
        bus.start = 1'b1; bus.opr1 = 32'd20; bus.opr2 = 32'd3;
        for (int c = 1; c <= 33; c++) @(negedge clk);
        chk("done reached", 64'(bus.ready), 64'd1);
        bus.cancel = 1'b1;
        bus.start  = 1'b0;
        #1;
        chk("done cancel ready", 64'(bus.ready), 64'd0);
        chk("done cancel res", bus.res, last_res);
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("done cancel busy", 64'(bus.busy), 64'd0);
        chk("done cancel res held", bus.res, last_res);

        // Cancel in IDLE blocks the accept.
        bus.start = 1'b1; bus.cancel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("idle cancel busy", 64'(bus.busy), 64'd0);

        // Back-to-back with start held; operand change during BUSY is ignored.
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opr1 = 32'd100; bus.opr2 = 32'd7;
        n = 0;
        begin
            int first, second;
            first = 0; second = 0;
            for (int c = 1; c <= 80 && second == 0; c++) begin
                @(negedge clk);
                if (c == 5) begin bus.opr1 = 32'd50; bus.opr2 = 32'd5; end
                if (bus.ready) begin
                    if (first == 0) begin
                        first = c;
                        chk("b2b first res", bus.res, {32'h2, 32'hE});
                    end else begin
                        second = c;
                        chk("b2b second res", bus.res, {32'h0, 32'hA});
                    end
                end
            end
            chk("b2b first at", 64'(first), 64'd33);
            chk("b2b gap", 64'(second - first), 64'd34);
        end
        bus.start = 1'b0;
        @(negedge clk);
        last_res = {32'h0, 32'hA};

        // Asynchronous reset mid-operation.
        bus.start = 1'b1; bus.opr1 = 32'd100; bus.opr2 = 32'd7;
        for (int c = 1; c <= 15; c++) @(negedge clk);
        resetn = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("async rst ready", 64'(bus.ready), 64'd0);
        chk("async rst busy", 64'(bus.busy), 64'd0);
        chk("async rst res", bus.res, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ready || bus.busy) n++;
        end
        chk("no stale ready", 64'(n), 64'd0);
        run_op(32'd1, 32'd1, 1'b0, {32'h0, 32'h1}, "post rst 1/1");

        // Randomized operands against the reference model.
        for (int i = 0; i < 24; i++) begin
            a  = $urandom;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = -($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (i % 6 == 0) a = 32'h8000_0000;
            run_op(a, b, sg, ref_div(a, b, sg), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
